// File: rtl/gdsp_pkg.sv
// Shared DSP types and constants for the transmit chain: sample format, oversampling
// ratio and the 16-QAM Gray constellation levels.
package gdsp_pkg;

  localparam int SAMPLE_W = 12;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int SPS = 4;

  // Constellation levels in Q1.11, normalised so the outer points sit at ~0.949 full scale
  localparam sample_t QAM_NEG3 = -12'sd1943;
  localparam sample_t QAM_NEG1 = -12'sd648;
  localparam sample_t QAM_POS1 = 12'sd648;
  localparam sample_t QAM_POS3 = 12'sd1943;

  // LSB position of the I field in a 16-QAM symbol: sym[3:2] -> I, sym[1:0] -> Q
  localparam int QAM_GRAY_IQ_SPLIT = 2;

  function automatic sample_t qam16_gray_level(input logic [1:0] bits);
    sample_t lvl;
    case (bits)
      2'b00:   lvl = QAM_NEG3;
      2'b01:   lvl = QAM_NEG1;
      2'b11:   lvl = QAM_POS1;
      default: lvl = QAM_POS3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_symbol_upsampler.sv
// 16-QAM Gray mapper and SPS zero-stuffer; one output sample per qualifying sample_en,
// registered one cycle later. Never stalls downstream; empty phase-0 slots emit zero and count.
module qam16_symbol_upsampler
  import gdsp_pkg::*;
#(
  parameter int SPS            = gdsp_pkg::SPS,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      sample_en,
  input  logic                      sym_valid,
  output logic                      sym_ready,
  input  logic [3:0]                sym_data,
  output logic                      out_valid,
  output sample_t                   out_i,
  output sample_t                   out_q,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  input  logic                      clr_status
);

  localparam int PH_W = $clog2(SPS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

  logic                      r_buf_full;
  logic [3:0]                r_buf_data;
  logic [PH_W-1:0]           r_phase;
  logic                      r_out_valid;
  sample_t                   r_out_i;
  sample_t                   r_out_q;
  logic                      r_underrun;
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  logic w_tick;
  logic w_slot;
  logic w_load;
  logic w_drain;
  logic w_under;

  // Load is only possible while empty and drain only while full, so they are exclusive
  assign w_tick  = sample_en && enable;
  assign w_slot  = w_tick && (r_phase == '0);
  assign w_load  = sym_valid && !r_buf_full;
  assign w_drain = w_slot && r_buf_full;
  assign w_under = w_slot && !r_buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (!enable) begin
      r_phase <= '0;
    end else if (sample_en) begin
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_load) begin
      r_buf_full <= 1'b1;
      r_buf_data <= sym_data;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else begin
      r_out_valid <= w_tick;
      if (w_tick) begin
        r_out_i <= w_drain ? qam16_gray_level(r_buf_data[QAM_GRAY_IQ_SPLIT +: 2]) : '0;
        r_out_q <= w_drain ? qam16_gray_level(r_buf_data[0 +: 2]) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (clr_status) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_under) begin
      r_underrun <= 1'b1;
      if (r_underrun_cnt != '1) begin
        r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
      end
    end
  end

  assign sym_ready    = !r_buf_full;
  assign out_valid    = r_out_valid;
  assign out_i        = r_out_i;
  assign out_q        = r_out_q;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_qam16_symbol_upsampler.sv
// Self-checking bench for qam16_symbol_upsampler: randomized symbols and sample_en pacing
// against a queue-based reference of the symbol slot / zero-stuff behaviour.
module tb_qam16_symbol_upsampler;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               sample_en;
  logic               sym_valid;
  logic               sym_ready;
  logic [3:0]         sym_data;
  logic               out_valid;
  logic signed [11:0] out_i;
  logic signed [11:0] out_q;
  logic               underrun;
  logic [15:0]        underrun_cnt;
  logic               clr_status;

  logic               s_enable;
  logic               s_sample_en;
  logic               s_sym_ready;
  logic               s_out_valid;
  logic signed [11:0] s_out_i;
  logic signed [11:0] s_out_q;
  logic               s_underrun;
  logic [1:0]         s_underrun_cnt;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qam16_symbol_upsampler #(.SPS(4), .UNDERRUN_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_en(sample_en),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .clr_status(clr_status)
  );

  // Narrow counter instance so saturation is reachable in a few slots
  qam16_symbol_upsampler #(.SPS(4), .UNDERRUN_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .sample_en(s_sample_en),
    .sym_valid(1'b0), .sym_ready(s_sym_ready), .sym_data(4'h0),
    .out_valid(s_out_valid), .out_i(s_out_i), .out_q(s_out_q),
    .underrun(s_underrun), .underrun_cnt(s_underrun_cnt), .clr_status(1'b0)
  );

  function automatic logic signed [11:0] ref_level(input logic [1:0] b);
    int tbl [4];
    tbl = '{-1943, -648, 1943, 648};
    return 12'(tbl[b]);
  endfunction

  task automatic step(input logic se);
    sample_en = se;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; sample_en = 1'b0; sym_valid = 1'b0;
    sym_data = 4'h0; clr_status = 1'b0; s_enable = 1'b0; s_sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sym_ready !== 1'b1) begin errs++; $display("FAIL reset_sym_ready: got %b want 1", sym_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_i !== 12'sd0) begin errs++; $display("FAIL reset_out_i: got %0d want 0", out_i); end
    checks++; if (out_q !== 12'sd0) begin errs++; $display("FAIL reset_out_q: got %0d want 0", out_q); end
    checks++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (underrun_cnt !== 16'd0) begin errs++; $display("FAIL reset_cnt: got %0d want 0", underrun_cnt); end
    rst_n = 1'b1;
    step(1'b0);
  endtask

  task automatic test_all_symbols;
    int perm [16];
    logic signed [11:0] ei, eq, last_i, last_q;
    last_i = '0; last_q = '0;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sym_valid = 1'b1;
      sym_data  = 4'(perm[i]);
      step(1'b0);
      sym_valid = 1'b0;
      checks++; if (sym_ready !== 1'b0) begin errs++; $display("FAIL sym_ready_after_load: sym %0d got %b want 0", perm[i], sym_ready); end
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(2, 0)) begin
          step(1'b0);
          checks++;
          if (out_valid !== 1'b0 || out_i !== last_i || out_q !== last_q) begin
            errs++;
            $display("FAIL gap_hold: sym %0d v=%b i=%0d q=%0d want v=0 i=%0d q=%0d", perm[i], out_valid, out_i, out_q, last_i, last_q);
          end
        end
        ei = (k == 0) ? ref_level(sym_data[3:2]) : 12'sd0;
        eq = (k == 0) ? ref_level(sym_data[1:0]) : 12'sd0;
        step(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_i !== ei || out_q !== eq) begin
          errs++;
          $display("FAIL map_sym: sym %0h phase %0d v=%b i=%0d q=%0d want v=1 i=%0d q=%0d", perm[i], k, out_valid, out_i, out_q, ei, eq);
        end
        last_i = ei; last_q = eq;
      end
    end
    checks++; if (underrun !== 1'b0) begin errs++; $display("FAIL no_underrun_when_fed: got %b want 0", underrun); end
  endtask

  task automatic test_underrun;
    enable = 1'b1; sym_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_i !== 12'sd0 || out_q !== 12'sd0) begin
        errs++;
        $display("FAIL underrun_sample: n=%0d v=%b i=%0d q=%0d want v=1 i=0 q=0", n, out_valid, out_i, out_q);
      end
      checks++;
      if (underrun_cnt !== 16'(n / 4 + 1)) begin
        errs++;
        $display("FAIL underrun_count_step: n=%0d got %0d want %0d", n, underrun_cnt, n / 4 + 1);
      end
    end
    checks++; if (underrun !== 1'b1) begin errs++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    clr_status = 1'b1;
    step(1'b0);
    clr_status = 1'b0;
    checks++; if (underrun !== 1'b0 || underrun_cnt !== 16'd0) begin errs++; $display("FAIL clr_status: flag=%b cnt=%0d want 0/0", underrun, underrun_cnt); end
    clr_status = 1'b1;
    step(1'b1);
    clr_status = 1'b0;
    checks++; if (underrun !== 1'b0 || underrun_cnt !== 16'd0) begin errs++; $display("FAIL clr_priority: flag=%b cnt=%0d want 0/0", underrun, underrun_cnt); end
    repeat (3) step(1'b1);
    checks++; if (underrun_cnt !== 16'd0) begin errs++; $display("FAIL zero_stuff_no_count: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] q[$];
    logic [3:0] d;
    logic se, acc;
    logic signed [11:0] ei, eq;
    int ph, accepts, slots, i, guard;
    ph = 0; accepts = 0; slots = 0; i = 0; guard = 0;
    enable = 1'b1;
    while ((i < 40 || ph != 0 || q.size() != 0) && guard < 300) begin
      sym_valid = (i < 40);
      sym_data  = 4'($urandom);
      se        = (i == 0) ? 1'b0 : 1'($urandom_range(1, 0));
      checks++;
      if (sym_ready !== (q.size() == 0)) begin
        errs++;
        $display("FAIL b2b_sym_ready: cycle %0d got %b want %b", i, sym_ready, q.size() == 0);
      end
      acc = sym_valid && (q.size() == 0);
      ei = '0; eq = '0;
      if (se) begin
        if (ph == 0) begin
          slots++;
          if (q.size() != 0) begin
            d  = q.pop_front();
            ei = ref_level(d[3:2]);
            eq = ref_level(d[1:0]);
          end
        end
        ph = (ph + 1) % 4;
      end
      if (acc) begin
        q.push_back(sym_data);
        accepts++;
      end
      step(se);
      checks++;
      if (out_valid !== se || (se && (out_i !== ei || out_q !== eq))) begin
        errs++;
        $display("FAIL b2b_sample: cycle %0d v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", i, out_valid, out_i, out_q, se, ei, eq);
      end
      i++; guard++;
    end
    sym_valid = 1'b0;
    checks++; if (guard >= 300) begin errs++; $display("FAIL b2b_timeout: got %0d cycles want < 300", guard); end
    checks++; if (accepts != slots) begin errs++; $display("FAIL b2b_one_per_slot: accepts=%0d want %0d", accepts, slots); end
    checks++; if (underrun !== 1'b0) begin errs++; $display("FAIL b2b_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_enable;
    logic [3:0] a, b, c;
    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
    enable = 1'b1;
    sym_valid = 1'b1; sym_data = a; step(1'b0); sym_valid = 1'b0;
    step(1'b1);
    checks++; if (out_i !== ref_level(a[3:2]) || out_q !== ref_level(a[1:0])) begin errs++; $display("FAIL en_first: i=%0d q=%0d want %0d %0d", out_i, out_q, ref_level(a[3:2]), ref_level(a[1:0])); end
    sym_valid = 1'b1; sym_data = b; step(1'b0); sym_valid = 1'b0;
    step(1'b1);
    enable = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step((n == 0) ? 1'b1 : 1'($urandom_range(1, 0)));
      checks++;
      if (out_valid !== 1'b0 || sym_ready !== 1'b0 || underrun !== 1'b0) begin
        errs++;
        $display("FAIL en_low_idle: n=%0d v=%b rdy=%b und=%b want 0 0 0", n, out_valid, sym_ready, underrun);
      end
    end
    enable = 1'b1;
    step(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_i !== ref_level(b[3:2]) || out_q !== ref_level(b[1:0])) begin
      errs++;
      $display("FAIL en_resume_phase0: v=%b i=%0d q=%0d want 1 %0d %0d", out_valid, out_i, out_q, ref_level(b[3:2]), ref_level(b[1:0]));
    end
    repeat (3) step(1'b1);
    enable = 1'b0;
    sym_valid = 1'b1; sym_data = c; step(1'b1); sym_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b0) begin errs++; $display("FAIL en_low_accept: v=%b rdy=%b want 0 0", out_valid, sym_ready); end
    enable = 1'b1;
    step(1'b1);
    checks++;
    if (out_i !== ref_level(c[3:2]) || out_q !== ref_level(c[1:0])) begin
      errs++;
      $display("FAIL en_low_loaded_emit: i=%0d q=%0d want %0d %0d", out_i, out_q, ref_level(c[3:2]), ref_level(c[1:0]));
    end
    repeat (3) step(1'b1);
  endtask

  task automatic test_reset_mid;
    logic [3:0] x, y;
    x = 4'($urandom); y = 4'($urandom);
    enable = 1'b1;
    sym_valid = 1'b1; sym_data = x; step(1'b0);
    sym_data = y; step(1'b1);
    checks++; if (sym_ready !== 1'b1 || out_i !== ref_level(x[3:2])) begin errs++; $display("FAIL rst_setup_drain: rdy=%b i=%0d want 1 %0d", sym_ready, out_i, ref_level(x[3:2])); end
    step(1'b0);
    sym_valid = 1'b0;
    checks++; if (sym_ready !== 1'b0) begin errs++; $display("FAIL rst_setup_full: rdy=%b want 0", sym_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_i !== 12'sd0 || out_q !== 12'sd0 || sym_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: i=%0d q=%0d rdy=%b v=%b want 0 0 1 0", out_i, out_q, sym_ready, out_valid);
    end
    #2 rst_n = 1'b1;
    step(1'b0);
    for (int n = 0; n < 4; n++) begin
      step(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_i !== 12'sd0 || out_q !== 12'sd0) begin
        errs++;
        $display("FAIL rst_discard: n=%0d v=%b i=%0d q=%0d want 1 0 0", n, out_valid, out_i, out_q);
      end
    end
    checks++; if (underrun !== 1'b1 || underrun_cnt !== 16'd1) begin errs++; $display("FAIL rst_phase0_underrun: flag=%b cnt=%0d want 1 1", underrun, underrun_cnt); end
  endtask

  task automatic test_saturation;
    int expc;
    s_enable = 1'b1;
    for (int n = 0; n < 24; n++) begin
      s_sample_en = 1'b1;
      @(posedge clk);
      #1;
      s_sample_en = 1'b0;
      if (n % 4 == 0) begin
        expc = (n / 4 + 1 > 3) ? 3 : n / 4 + 1;
        checks++;
        if (s_underrun_cnt !== 2'(expc)) begin
          errs++;
          $display("FAIL cnt_saturate: slot %0d got %0d want %0d", n / 4, s_underrun_cnt, expc);
        end
      end
    end
    checks++; if (s_underrun !== 1'b1) begin errs++; $display("FAIL sat_flag: got %b want 1", s_underrun); end
    s_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_symbols();
    test_underrun();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
